// File: rtl/nf2_reg_master_pkg.sv
// Shared definitions for the nf2 register-bus initiator: FSM state encodings
// and the data word returned when a slave never answers.
package nf2_reg_master_pkg;

  // Transaction FSM states; encodings are fixed so debug tools can decode them.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  // Same marker word the slaves return for unmapped addresses.
  localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hdead_beef;

endpackage

// File: rtl/nf2_reg_master.sv
// Register-bus initiator: takes one command on a valid/ready port, runs exactly
// one edge-triggered reg_req/reg_ack transaction, and returns the read data (or
// a timeout marker) on a valid/ready response port. All outputs are registered.
module nf2_reg_master
  import nf2_reg_master_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = 16,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           TIMEOUT_CYCLES = 64,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  // command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rd_wr_L,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wr_data,
  // response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rd_data,
  output logic                  rsp_rd_wr_L,
  output logic                  rsp_timeout,
  // register bus
  output logic                  reg_req,
  output logic                  reg_rd_wr_L,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  input  logic                  reg_ack,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  output logic                  stray_ack
);

  // One extra bit so the saturation point sits above the timeout threshold.
  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_e                  state_q,       state_d;
  logic [CNT_W-1:0]        cnt_q,         cnt_d;
  logic                    cmd_ready_q,   cmd_ready_d;
  logic                    rsp_valid_q,   rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rd_data_q, rsp_rd_data_d;
  logic                    rsp_rd_wr_L_q, rsp_rd_wr_L_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic                    reg_req_q,     reg_req_d;
  logic                    reg_rd_wr_L_q, reg_rd_wr_L_d;
  logic [ADDR_WIDTH-1:0]   reg_addr_q,    reg_addr_d;
  logic [DATA_WIDTH-1:0]   reg_wr_data_q, reg_wr_data_d;
  logic                    stray_ack_q,   stray_ack_d;

  logic                    cmd_accept_s;
  logic                    rsp_hs_s;
  logic                    cnt_last_s;
  logic [CNT_W-1:0]        cnt_inc_s;

  // cmd_ready is only ever high in IDLE; the state term keeps accept safe anyway.
  assign cmd_accept_s = cmd_valid & cmd_ready_q & (state_q == ST_IDLE);
  assign rsp_hs_s     = rsp_valid_q & rsp_ready;
  assign cnt_last_s   = (cnt_q >= CNT_LAST);
  // Saturating increment: the counter never wraps back to zero.
  assign cnt_inc_s    = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

  // Next-state and next-output logic for the IDLE/REQ/RSP transaction FSM.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_ready_d   = 1'b0;
    rsp_valid_d   = rsp_valid_q;
    rsp_rd_data_d = rsp_rd_data_q;
    rsp_rd_wr_L_d = rsp_rd_wr_L_q;
    rsp_timeout_d = rsp_timeout_q;
    reg_req_d     = reg_req_q;
    reg_rd_wr_L_d = reg_rd_wr_L_q;
    reg_addr_d    = reg_addr_q;
    reg_wr_data_d = reg_wr_data_q;
    // Any ack outside REQ (late ack after timeout, spurious ack) is flagged
    // and otherwise ignored.
    stray_ack_d   = reg_ack & (state_q != ST_REQ);

    case (state_q)
      ST_IDLE: begin
        reg_req_d = 1'b0;
        cnt_d     = CNT_ZERO;
        if (cmd_accept_s) begin
          reg_rd_wr_L_d = cmd_rd_wr_L;
          reg_addr_d    = cmd_addr;
          reg_wr_data_d = cmd_wr_data;
          reg_req_d     = 1'b1;
          cmd_ready_d   = 1'b0;
          state_d       = ST_REQ;
        end else begin
          cmd_ready_d   = 1'b1;
          state_d       = ST_IDLE;
        end
      end

      ST_REQ: begin
        cmd_ready_d = 1'b0;
        // Ack is checked first so an ack on the timeout cycle still completes.
        if (reg_ack) begin
          rsp_rd_data_d = reg_rd_data;
          rsp_timeout_d = 1'b0;
          rsp_rd_wr_L_d = reg_rd_wr_L_q;
          rsp_valid_d   = 1'b1;
          reg_req_d     = 1'b0;
          cnt_d         = CNT_ZERO;
          state_d       = ST_RSP;
        end else if (cnt_last_s) begin
          rsp_rd_data_d = TIMEOUT_DATA;
          rsp_timeout_d = 1'b1;
          rsp_rd_wr_L_d = reg_rd_wr_L_q;
          rsp_valid_d   = 1'b1;
          reg_req_d     = 1'b0;
          cnt_d         = CNT_ZERO;
          state_d       = ST_RSP;
        end else begin
          reg_req_d     = 1'b1;
          cnt_d         = cnt_inc_s;
          state_d       = ST_REQ;
        end
      end

      ST_RSP: begin
        // reg_req stays low here; together with the IDLE accept cycle this
        // gives every slave at least two low cycles before the next edge.
        reg_req_d = 1'b0;
        cnt_d     = CNT_ZERO;
        if (rsp_hs_s) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = ST_RSP;
        end
      end

      default: begin
        // Unused encoding: drop the bus and fall back to IDLE.
        reg_req_d   = 1'b0;
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b0;
        cnt_d       = CNT_ZERO;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= CNT_ZERO;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rd_data_q <= {DATA_WIDTH{1'b0}};
      rsp_rd_wr_L_q <= 1'b0;
      rsp_timeout_q <= 1'b0;
      reg_req_q     <= 1'b0;
      reg_rd_wr_L_q <= 1'b1;
      reg_addr_q    <= {ADDR_WIDTH{1'b0}};
      reg_wr_data_q <= {DATA_WIDTH{1'b0}};
      stray_ack_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rd_data_q <= rsp_rd_data_d;
      rsp_rd_wr_L_q <= rsp_rd_wr_L_d;
      rsp_timeout_q <= rsp_timeout_d;
      reg_req_q     <= reg_req_d;
      reg_rd_wr_L_q <= reg_rd_wr_L_d;
      reg_addr_q    <= reg_addr_d;
      reg_wr_data_q <= reg_wr_data_d;
      stray_ack_q   <= stray_ack_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rd_data = rsp_rd_data_q;
  assign rsp_rd_wr_L = rsp_rd_wr_L_q;
  assign rsp_timeout = rsp_timeout_q;
  assign reg_req     = reg_req_q;
  assign reg_rd_wr_L = reg_rd_wr_L_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wr_data = reg_wr_data_q;
  assign stray_ack   = stray_ack_q;

endmodule

// File: tb/tb_nf2_reg_master.sv
// Directed bench for nf2_reg_master: a vector table of single transactions
// against an edge-detecting slave model, plus hand-written sequences for
// timeout with late ack, back-to-back commands and reset mid-transaction.
module tb_nf2_reg_master;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_rd_wr_L = 1'b1;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wr_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rd_data;
  logic          rsp_rd_wr_L;
  logic          rsp_timeout;
  logic          reg_req;
  logic          reg_rd_wr_L;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wr_data;
  logic          reg_ack = 1'b0;
  logic [DW-1:0] reg_rd_data = '0;
  logic          stray_ack;

  nf2_reg_master dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd_wr_L(cmd_rd_wr_L),
    .cmd_addr(cmd_addr), .cmd_wr_data(cmd_wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd_data(rsp_rd_data),
    .rsp_rd_wr_L(rsp_rd_wr_L), .rsp_timeout(rsp_timeout),
    .reg_req(reg_req), .reg_rd_wr_L(reg_rd_wr_L), .reg_addr(reg_addr),
    .reg_wr_data(reg_wr_data), .reg_ack(reg_ack), .reg_rd_data(reg_rd_data),
    .stray_ack(stray_ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Slave model controls (written by the test only).
  int          slave_delay = 1;      // ack this many cycles after the rising edge; -1 = never
  logic [31:0] slave_data  = 32'h0;
  int          stray_req   = 0;      // bump to force one ack in the current cycle

  // Slave model state (written by the slave only).
  int          stray_done  = 0;
  int          edges       = 0;
  int          req_hi_cnt  = 0;
  int          unstable    = 0;
  int          age         = 0;
  logic        req_prev    = 1'b0;
  logic [AW-1:0] cap_addr  = '0;
  logic [DW-1:0] cap_wd    = '0;
  logic          cap_rw    = 1'b0;

  // Edge-detecting slave: drives ack/data mid-cycle so the DUT samples it at the next posedge.
  always @(negedge clk) begin
    reg_ack     = 1'b0;
    reg_rd_data = 32'h5555_aaaa;
    if (reg_req === 1'b1) begin
      if (!req_prev) begin
        edges++;
        age = 0;
        cap_addr = reg_addr; cap_wd = reg_wr_data; cap_rw = reg_rd_wr_L;
      end else begin
        age++;
        if (reg_addr !== cap_addr || reg_wr_data !== cap_wd || reg_rd_wr_L !== cap_rw)
          unstable++;
      end
      req_hi_cnt++;
      if (slave_delay >= 0 && age == slave_delay) begin
        reg_ack = 1'b1;
        reg_rd_data = slave_data;
      end
    end
    if (stray_req != stray_done) begin
      reg_ack = 1'b1;
      reg_rd_data = 32'h0bad_0bad;
      stray_done++;
    end
    req_prev = (reg_req === 1'b1);
  end

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int            dly;
    logic [DW-1:0] sdata;
    logic          exp_to;
    logic [DW-1:0] exp_rd;
    int            exp_hi;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin step(); n++; end
    chk("ready_wait", {31'b0, cmd_ready}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_cmd_ready"},   {31'b0, cmd_ready},   32'd0);
    chk({p, "_rsp_valid"},   {31'b0, rsp_valid},   32'd0);
    chk({p, "_rsp_timeout"}, {31'b0, rsp_timeout}, 32'd0);
    chk({p, "_rsp_rd_data"}, rsp_rd_data,          32'd0);
    chk({p, "_rsp_rd_wr_L"}, {31'b0, rsp_rd_wr_L}, 32'd0);
    chk({p, "_reg_req"},     {31'b0, reg_req},     32'd0);
    chk({p, "_reg_rd_wr_L"}, {31'b0, reg_rd_wr_L}, 32'd1);
    chk({p, "_reg_addr"},    {16'b0, reg_addr},    32'd0);
    chk({p, "_reg_wr_data"}, reg_wr_data,          32'd0);
    chk({p, "_stray_ack"},   {31'b0, stray_ack},   32'd0);
  endtask

  // One complete transaction with rsp_ready=1; checks latency, fields and bus stability.
  task automatic run_txn(input vec_t v, input string p);
    int n;
    int hi_base;
    int uns_base;
    wait_ready();
    slave_delay = v.dly; slave_data = v.sdata; rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_rd_wr_L = v.rw; cmd_addr = v.addr; cmd_wr_data = v.wd;
    hi_base = req_hi_cnt; uns_base = unstable;
    step();  // cycle 1
    cmd_valid = 1'b0; cmd_rd_wr_L = ~v.rw; cmd_addr = ~v.addr; cmd_wr_data = ~v.wd;
    chk({p, "_req_c1"},  {31'b0, reg_req},     32'd1);
    chk({p, "_addr"},    {16'b0, reg_addr},    {16'b0, v.addr});
    chk({p, "_rw"},      {31'b0, reg_rd_wr_L}, {31'b0, v.rw});
    chk({p, "_wd"},      reg_wr_data,          v.wd);
    n = 1;
    while (rsp_valid !== 1'b1 && n < 200) begin step(); n++; end
    chk({p, "_rsp_cyc"}, n, v.exp_hi + 1);
    chk({p, "_rd"},      rsp_rd_data,          v.exp_rd);
    chk({p, "_to"},      {31'b0, rsp_timeout}, {31'b0, v.exp_to});
    chk({p, "_rsp_rw"},  {31'b0, rsp_rd_wr_L}, {31'b0, v.rw});
    chk({p, "_req_hi"},  req_hi_cnt - hi_base, v.exp_hi);
    chk({p, "_stable"},  unstable - uns_base,  32'd0);
    chk({p, "_nostray"}, {31'b0, stray_ack},   32'd0);
    step();
    chk({p, "_rsp_drop"}, {31'b0, rsp_valid},  32'd0);
    chk({p, "_ready_back"}, {31'b0, cmd_ready}, 32'd1);
  endtask

  vec_t vecs [6];

  initial begin
    int n;
    int acc, rsps, last_acc, gap, min_gap, nedge, eb, diffs;
    logic prev;

    //           rw    addr        wd             dly sdata          to    exp_rd         hi
    vecs[0] = '{1'b1, 16'h0002, 32'h0000_0000,  1, 32'h0000_1234, 1'b0, 32'h0000_1234,  2};
    vecs[1] = '{1'b0, 16'h0000, 32'hA5A5_0001,  1, 32'h0000_0077, 1'b0, 32'h0000_0077,  2};
    vecs[2] = '{1'b1, 16'h1234, 32'hffff_ffff,  5, 32'hcafe_f00d, 1'b0, 32'hcafe_f00d,  6};
    vecs[3] = '{1'b1, 16'h0abc, 32'h0000_0000, -1, 32'h0000_0000, 1'b1, 32'hdead_beef, 64};
    vecs[4] = '{1'b0, 16'h00ff, 32'h1357_9bdf, 63, 32'h0000_abcd, 1'b0, 32'h0000_abcd, 64};
    vecs[5] = '{1'b1, 16'hffff, 32'h0000_0000,  0, 32'h8000_0001, 1'b0, 32'h8000_0001,  1};

    // Reset state
    step(); step(); step();
    chk_reset_vals("rst");
    reset = 1'b0;
    step();
    chk("rst_ready_after", {31'b0, cmd_ready}, 32'd1);

    // Vector table
    for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("v%0d", i));

    // Timeout with rsp_ready low, then a late ack in cycle 66
    wait_ready();
    slave_delay = -1; rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_rd_wr_L = 1'b1; cmd_addr = 16'h0010; cmd_wr_data = 32'h0;
    n = 0;
    step(); n++; cmd_valid = 1'b0;
    while (rsp_valid !== 1'b1 && n < 200) begin step(); n++; end
    chk("late_rsp_cyc", n, 32'd65);
    chk("late_to", {31'b0, rsp_timeout}, 32'd1);
    step();  // cycle 66
    stray_req++;
    step();  // cycle 67
    chk("late_stray", {31'b0, stray_ack}, 32'd1);
    chk("late_rd_held", rsp_rd_data, 32'hdead_beef);
    chk("late_to_held", {31'b0, rsp_timeout}, 32'd1);
    chk("late_valid_held", {31'b0, rsp_valid}, 32'd1);
    chk("late_req_low", {31'b0, reg_req}, 32'd0);
    step();  // cycle 68
    chk("late_stray_once", {31'b0, stray_ack}, 32'd0);
    rsp_ready = 1'b1;
    step();
    chk("late_hs", {31'b0, rsp_valid}, 32'd0);
    run_txn(vecs[0], "after_late");

    // Back-to-back: cmd_valid held high, rsp_ready=1
    wait_ready();
    slave_delay = 1; slave_data = 32'h0000_0042; rsp_ready = 1'b1;
    acc = 0; rsps = 0; last_acc = -1; gap = 0; min_gap = 1000; nedge = 0;
    eb = edges; prev = 1'b0;
    for (int k = 0; k < 80 && rsps < 4; k++) begin
      if (k > 0) step();
      if (rsp_valid === 1'b1 && rsp_ready) rsps++;
      if (reg_req === 1'b1 && !prev) begin
        if (nedge > 0 && gap < min_gap) min_gap = gap;
        nedge++;
      end
      if (reg_req === 1'b1) gap = 0; else gap++;
      prev = (reg_req === 1'b1);
      cmd_valid = (acc < 4);
      cmd_addr = AW'(acc);
      if (cmd_valid && cmd_ready === 1'b1) begin acc++; last_acc = k; end
    end
    cmd_valid = 1'b0;
    chk("b2b_rsps", rsps, 32'd4);
    chk("b2b_edges_tb", nedge, 32'd4);
    chk("b2b_edges_slave", edges - eb, 32'd4);
    chk("b2b_gap_ge2", {31'b0, (min_gap >= 2)}, 32'd1);
    chk("b2b_last_accept", last_acc, 32'd12);
    step();

    // rsp_ready held low for 10 cycles, then reset in REQ of the next command
    wait_ready();
    slave_delay = 2; slave_data = 32'h1111_2222; rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_rd_wr_L = 1'b1; cmd_addr = 16'h0042; cmd_wr_data = 32'h0;
    n = 0;
    step(); n++; cmd_valid = 1'b0;
    while (rsp_valid !== 1'b1 && n < 200) begin step(); n++; end
    chk("hold_rsp_cyc", n, 32'd4);
    diffs = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rd_data !== 32'h1111_2222 ||
          rsp_timeout !== 1'b0 || rsp_rd_wr_L !== 1'b1) diffs++;
      cmd_valid = 1'b1; cmd_addr = 16'h7777;  // must be ignored outside IDLE
      step();
    end
    cmd_valid = 1'b0;
    chk("hold_stable", diffs, 32'd0);
    chk("hold_no_req", {31'b0, reg_req}, 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("hold_hs", {31'b0, rsp_valid}, 32'd0);
    wait_ready();
    slave_delay = -1;
    cmd_valid = 1'b1; cmd_rd_wr_L = 1'b0; cmd_addr = 16'h0077; cmd_wr_data = 32'hfeed_0000;
    step();  // cycle 1
    cmd_valid = 1'b0;
    chk("rr_req_c1", {31'b0, reg_req}, 32'd1);
    step();  // cycle 2, in REQ
    reset = 1'b1;
    step();  // cycle 3
    reset = 1'b0;
    chk_reset_vals("rr");
    step();
    chk("rr_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rr_req_low", {31'b0, reg_req}, 32'd0);
    step(); step();
    chk("rr_no_rsp", {31'b0, rsp_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
